shift_scheduler: RTL and testbench

Sequencer and two-port arbiter for the execute-stage right-shift barrel shifter (5-stage 16/8/4/2/1 chain, logical or arithmetic, right only). Accepts shift requests from two requesters over valid/ready handshakes and arbitrates them round-robin. Implements SRL/SRA directly, SLL by bit-reversing input and output, and ROR as a two-pass sequence on the single shifter. Returns a registered result to the granted requester.

---
 rtl/shift_scheduler.sv | 107 ++++++++++
 tb/tb_shift_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_scheduler.sv
// shift_scheduler: round-robin two-port front end for a single right-only barrel shifter.
// SLL is done by bit-reversal around the shifter; ROR takes two passes through it.
module shift_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_data_0,
    input  logic [31:0] req_data_1,
    input  logic [4:0]  req_shamt_0,
    input  logic [4:0]  req_shamt_1,
    input  logic [1:0]  req_op_0,
    input  logic [1:0]  req_op_1,
    output logic        resp_valid_0,
    output logic        resp_valid_1,
    input  logic        resp_ready_0,
    input  logic        resp_ready_1,
    output logic [31:0] resp_data
);
    typedef enum logic [1:0] {IDLE, ROT2, DONE} state_t;
    localparam logic [1:0] OP_SRA = 2'b01, OP_SLL = 2'b10, OP_ROR = 2'b11;

    state_t      r_state, w_next;
    logic        r_owner, r_last_grant;
    logic [4:0]  r_shamt;
    logic [31:0] r_operand, r_partial, r_resp_data;

    logic        w_resp_ready_own, w_can_accept, w_accept, w_win, w_rot2;
    logic [31:0] w_data, w_sh_src, w_sh_in, w_sh_out, w_sh_res;
    logic [4:0]  w_shamt, w_sh_amt;
    logic [1:0]  w_op;
    logic        w_sh_rev, w_sh_arith;

    function automatic logic [31:0] f_rev(input logic [31:0] x);
        return {<<{x}};
    endfunction

    // 16/8/4/2/1 stage chain, fill bit is the operand sign for arithmetic shifts
    function automatic logic [31:0] f_shr(input logic [31:0] x, input logic [4:0] a, input logic s);
        logic [31:0] y;
        y = x;
        for (int k = 4; k >= 0; k--)
            if (a[k]) y = 32'({{32{s & x[31]}}, y} >> (1 << k));
        return y;
    endfunction

    assign w_resp_ready_own = r_owner ? resp_ready_1 : resp_ready_0;
    assign w_can_accept     = (r_state == IDLE || (r_state == DONE && w_resp_ready_own)) && !flush;
    assign w_accept         = req_ready_0 | req_ready_1;
    assign w_win            = req_ready_1;
    assign w_data           = w_win ? req_data_1  : req_data_0;
    assign w_shamt          = w_win ? req_shamt_1 : req_shamt_0;
    assign w_op             = w_win ? req_op_1    : req_op_0;
    assign w_rot2           = w_op == OP_ROR && w_shamt != 5'd0;

    // second ROR pass reuses the shifter as SLL by (32 - shamt) mod 32
    assign w_sh_rev   = r_state == ROT2 || w_op == OP_SLL;
    assign w_sh_arith = r_state != ROT2 && w_op == OP_SRA;
    assign w_sh_amt   = r_state == ROT2 ? 5'd0 - r_shamt : w_shamt;
    assign w_sh_src   = r_state == ROT2 ? r_operand : w_data;
    assign w_sh_in    = w_sh_rev ? f_rev(w_sh_src) : w_sh_src;
    assign w_sh_out   = f_shr(w_sh_in, w_sh_amt, w_sh_arith);
    assign w_sh_res   = w_sh_rev ? f_rev(w_sh_out) : w_sh_out;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (flush) w_next = IDLE;
        else if (r_state == ROT2) w_next = DONE;
        else if (w_accept) w_next = w_rot2 ? ROT2 : DONE;
        else if (r_state == DONE ? w_resp_ready_own : r_state != IDLE) w_next = IDLE;
    end

    always_comb begin
        req_ready_0  = w_can_accept && req_valid_0 && (!req_valid_1 || r_last_grant);
        req_ready_1  = w_can_accept && req_valid_1 && (!req_valid_0 || !r_last_grant);
        resp_valid_0 = r_state == DONE && !r_owner;
        resp_valid_1 = r_state == DONE && r_owner;
    end

    assign resp_data = r_resp_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_shamt      <= 5'd0;
            r_operand    <= 32'd0;
            r_partial    <= 32'd0;
            r_resp_data  <= 32'd0;
        end else if (w_accept) begin
            r_last_grant <= w_win;
            r_owner      <= w_win;
            r_shamt      <= w_shamt;
            r_operand    <= w_data;
            if (w_rot2) r_partial <= w_sh_res;
            else        r_resp_data <= w_sh_res;
        end else if (r_state == ROT2 && !flush) begin
            r_resp_data <= r_partial | w_sh_res;
        end
endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: directed and randomized checks of shift_scheduler against an arithmetic reference.
module tb_shift_scheduler;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_data  [2];
    logic [4:0]  req_shamt [2];
    logic [1:0]  req_op    [2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic [31:0] resp_data;
    int          tests = 0;
    int          fails = 0;

    shift_scheduler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid_0(req_valid[0]), .req_valid_1(req_valid[1]),
        .req_ready_0(req_ready[0]), .req_ready_1(req_ready[1]),
        .req_data_0(req_data[0]), .req_data_1(req_data[1]),
        .req_shamt_0(req_shamt[0]), .req_shamt_1(req_shamt[1]),
        .req_op_0(req_op[0]), .req_op_1(req_op[1]),
        .resp_valid_0(resp_valid[0]), .resp_valid_1(resp_valid[1]),
        .resp_ready_0(resp_ready[0]), .resp_ready_1(resp_ready[1]),
        .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        logic [63:0] w;
        w = {d, d} >> s;
        case (op)
            2'd0:    return d >> s;
            2'd1:    return $unsigned($signed(d) >>> s);
            2'd2:    return d << s;
            default: return w[31:0];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input int k, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        int n;
        req_valid[k] = 1;
        req_data[k]  = d;
        req_shamt[k] = s;
        req_op[k]    = op;
        #1;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            tick();
            n++;
        end
        chk("accept_in_budget", 32'(n < 20), 1);
        tick();
        req_valid[k] = 0;
    endtask

    task automatic do_op(input int k, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                         input logic [31:0] exp, input int stall);
        resp_ready[k] = (stall == 0);
        issue(k, d, s, op);
        if (op == 2'd3 && s != 0) begin
            chk("rot2_no_valid", 32'(resp_valid[k]), 0);
            tick();
        end
        chk("resp_valid_owner", 32'(resp_valid[k]), 1);
        chk("resp_valid_other", 32'(resp_valid[1-k]), 0);
        chk("resp_data", resp_data, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", 32'(resp_valid[k]), 1);
            chk("stall_data", resp_data, exp);
        end
        resp_ready[k] = 1;
        tick();
        chk("back_to_idle", 32'(resp_valid[k]), 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        int          w;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_data[i] = 0; req_shamt[i] = 0; req_op[i] = 0; resp_ready[i] = 1;
        end
        do_reset();
        chk("rst_valid0", 32'(resp_valid[0]), 0);
        chk("rst_valid1", 32'(resp_valid[1]), 0);
        chk("rst_data", resp_data, 0);
        chk("rst_ready0_idle", 32'(req_ready[0]), 0);

        do_op(0, 32'h8000_0000, 4, 2'd1, 32'hF800_0000, 0);
        do_op(0, 32'h8000_0000, 4, 2'd0, 32'h0800_0000, 0);
        do_op(1, 32'h0000_0001, 31, 2'd2, 32'h8000_0000, 0);
        do_op(1, 32'h0000_0001, 0, 2'd2, 32'h0000_0001, 0);
        do_op(0, 32'h1234_5678, 8, 2'd3, 32'h7812_3456, 1);
        do_op(0, 32'h1234_5678, 0, 2'd3, 32'h1234_5678, 0);

        // continuous contention after reset: strict alternation starting at requester 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w = i % 2;
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = 1; req_op[k] = 2'd0;
                req_data[k] = $urandom(); req_shamt[k] = 5'($urandom_range(0, 31));
            end
            exp = req_data[w] >> req_shamt[w];
            #1;
            chk("rr_ready_winner", 32'(req_ready[w]), 1);
            chk("rr_ready_loser", 32'(req_ready[1-w]), 0);
            tick();
            chk("rr_valid_winner", 32'(resp_valid[w]), 1);
            chk("rr_valid_loser", 32'(resp_valid[1-w]), 0);
            chk("rr_data", resp_data, exp);
        end
        req_valid[0] = 0; req_valid[1] = 0;
        tick();

        // pending result held while requester 0 stalls, then req1 accepted in the release cycle
        resp_ready[0] = 0;
        issue(0, 32'hFFFF_0000, 16, 2'd0);
        req_valid[1] = 1; req_data[1] = 32'h0000_00F0; req_shamt[1] = 4; req_op[1] = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_valid0", 32'(resp_valid[0]), 1);
            chk("hold_data", resp_data, 32'h0000_FFFF);
            chk("hold_ready0", 32'(req_ready[0]), 0);
            chk("hold_ready1", 32'(req_ready[1]), 0);
            tick();
        end
        resp_ready[0] = 1;
        #1;
        chk("release_ready1", 32'(req_ready[1]), 1);
        tick();
        req_valid[1] = 0;
        chk("release_valid1", 32'(resp_valid[1]), 1);
        chk("release_valid0", 32'(resp_valid[0]), 0);
        chk("release_data", resp_data, 32'h0000_000F);
        tick();

        // flush during the second rotate pass
        issue(0, 32'h1234_5678, 8, 2'd3);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_rot2_v0", 32'(resp_valid[0]), 0);
        chk("flush_rot2_v1", 32'(resp_valid[1]), 0);
        tick();
        chk("flush_rot2_later", 32'(resp_valid[0]), 0);
        req_valid[0] = 1; req_op[0] = 2'd0;
        #1;
        chk("flush_idle_ready", 32'(req_ready[0]), 1);
        req_valid[0] = 0;

        // flush drops an untaken result and blocks the same-cycle request
        resp_ready[0] = 0;
        issue(0, 32'h0000_0F00, 4, 2'd0);
        resp_ready[0] = 1; req_valid[1] = 1; flush = 1;
        #1;
        chk("flush_block_ready1", 32'(req_ready[1]), 0);
        tick();
        flush = 0; req_valid[1] = 0;
        chk("flush_drop_v0", 32'(resp_valid[0]), 0);
        chk("flush_drop_v1", 32'(resp_valid[1]), 0);

        // asynchronous reset while a result is pending
        resp_ready[0] = 0;
        issue(1, 32'h0000_0000, 0, 2'd0);
        issue(0, 32'hA5A5_A5A5, 0, 2'd0);
        chk("pre_rst_valid", 32'(resp_valid[0]), 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valid", 32'(resp_valid[0]), 0);
        chk("async_rst_data", resp_data, 0);
        tick();
        rst_n = 1; resp_ready[0] = 1;
        req_valid[0] = 1; req_valid[1] = 1;
        #1;
        chk("post_rst_ready0", 32'(req_ready[0]), 1);
        chk("post_rst_ready1", 32'(req_ready[1]), 0);
        req_valid[0] = 0; req_valid[1] = 0;
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic [1:0]  op;
            int          k;
            d  = $urandom();
            s  = 5'($urandom_range(0, 31));
            op = 2'($urandom_range(0, 3));
            k  = $urandom_range(0, 1);
            do_op(k, d, s, op, ref_model(d, s, op), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
